// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display arbiter: FSM states, data layout, one-hot helper.
package display_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, LINGER = 2'd2} state_t;

   localparam int NREQ    = 3;
   localparam int DAT_W   = 20;
   localparam int DIG_LSB = 4;
   localparam int DOT_LSB = 0;

   function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
      oh2idx = oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
   endfunction
endpackage

// File: rtl/display_arbiter_rr_pick3.sv
// Three-way round-robin pick: searches ptr+1, ptr+2, ptr+3 (mod 3) over req with excl masked out.
module rr_pick3
   import display_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   input  logic [NREQ-1:0] excl,
   output logic [NREQ-1:0] pick,
   output logic            valid
);
   logic [NREQ-1:0] elig;

   assign elig  = req & ~excl;
   assign valid = |elig;

   always_comb begin
      pick = '0;
      case (ptr)
         2'd0: begin
            if (elig[1])      pick = 3'b010;
            else if (elig[2]) pick = 3'b100;
            else if (elig[0]) pick = 3'b001;
         end
         2'd1: begin
            if (elig[2])      pick = 3'b100;
            else if (elig[0]) pick = 3'b001;
            else if (elig[1]) pick = 3'b010;
         end
         default: begin
            if (elig[0])      pick = 3'b001;
            else if (elig[1]) pick = 3'b010;
            else if (elig[2]) pick = 3'b100;
         end
      endcase
   end
endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 4-digit display with minimum hold and time-slicing.
// Optional dot blink of the owner's dots is enabled with DISPLAY_ARBITER_BLINK_EN.
module display_arbiter
   import display_arbiter_pkg::*;
#(
   parameter int          HOLD_CYC  = 50_000_000,
   parameter logic [15:0] IDLE_HEX  = 16'h0000,
   parameter logic [3:0]  IDLE_DOTS = 4'hF,
   parameter int          BLINK_CYC = 25_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [DAT_W-1:0] dat0,
   input  logic [DAT_W-1:0] dat1,
   input  logic [DAT_W-1:0] dat2,
   input  logic [NREQ-1:0]  blink,
   output logic [NREQ-1:0]  gnt,
   output logic [3:0]       hexa3,
   output logic [3:0]       hexa2,
   output logic [3:0]       hexa1,
   output logic [3:0]       hexa0,
   output logic [3:0]       puntos4,
   output logic             busy
);
   localparam int            CW   = $clog2(HOLD_CYC + 1);
   localparam logic [CW-1:0] HOLD = CW'(HOLD_CYC);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [1:0]       ptr_q, ptr_d;
   logic [NREQ-1:0]  gnt_q, gnt_d, pick, excl;
   logic [DAT_W-1:0] disp_q, disp_d, own_dat;
   logic             pick_vld, owner_req, expired, blink_on, phase;

   assign owner_req = |(req & gnt_q);
   assign expired   = (cnt_q >= HOLD);
   assign cnt_inc   = (cnt_q == HOLD) ? cnt_q : cnt_q + 1'b1;
   // Excluding the owner only matters when it is still requesting, i.e. a time-slice.
   assign excl      = (state_q == OWN) ? gnt_q : '0;

   rr_pick3 u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .excl  (excl),
      .pick  (pick),
      .valid (pick_vld)
   );

`ifdef DISPLAY_ARBITER_BLINK_EN
   localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   logic [BW-1:0] bcnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (bcnt == BW'(BLINK_CYC - 1)) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt  <= bcnt + 1'b1;
      end
   end

   assign blink_on = |(blink & gnt_q);
`else
   logic unused_blink;
   assign unused_blink = ^blink;
   assign blink_on     = 1'b0;
   assign phase        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= 2'd2;
         gnt_q   <= '0;
         disp_q  <= {IDLE_HEX, IDLE_DOTS};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         disp_q  <= disp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick_vld) begin
               state_d = OWN;
               gnt_d   = pick;
               ptr_d   = oh2idx(pick);
            end
         end
         OWN: begin
            cnt_d = cnt_inc;
            if (!owner_req && !expired) begin
               state_d = LINGER;
               gnt_d   = '0;
            end else if (expired && pick_vld) begin
               gnt_d = pick;
               ptr_d = oh2idx(pick);
               cnt_d = '0;
            end else if (!owner_req) begin
               state_d = IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
            end
         end
         LINGER: begin
            cnt_d = cnt_inc;
            if (expired) begin
               cnt_d = '0;
               if (pick_vld) begin
                  state_d = OWN;
                  gnt_d   = pick;
                  ptr_d   = oh2idx(pick);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
         end
      endcase
   end

   // Display follows the owner one edge behind the grant and freezes once the owner lets go.
   always_comb begin
      own_dat = ({DAT_W{gnt_q[0]}} & dat0) | ({DAT_W{gnt_q[1]}} & dat1) |
                ({DAT_W{gnt_q[2]}} & dat2);
      disp_d  = disp_q;
      if (state_d == IDLE) begin
         disp_d = {IDLE_HEX, IDLE_DOTS};
      end else if (state_q == OWN && state_d == OWN && owner_req) begin
         disp_d = own_dat;
         if (blink_on)
            disp_d[DOT_LSB +: 4] = own_dat[DOT_LSB +: 4] ^ {4{phase}};
      end
   end

   assign gnt     = gnt_q;
   assign busy    = (state_q != IDLE);
   assign hexa3   = disp_q[DIG_LSB + 12 +: 4];
   assign hexa2   = disp_q[DIG_LSB + 8  +: 4];
   assign hexa1   = disp_q[DIG_LSB + 4  +: 4];
   assign hexa0   = disp_q[DIG_LSB      +: 4];
   assign puntos4 = disp_q[DOT_LSB      +: 4];
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYC=4, BLINK_CYC=2.
module tb_display_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, blink, gnt;
   logic [19:0] dat0, dat1, dat2;
   logic [3:0]  hexa3, hexa2, hexa1, hexa0, puntos4;
   logic        busy;
   logic [15:0] hex;
   int          checks = 0;
   int          failures = 0;

   assign hex = {hexa3, hexa2, hexa1, hexa0};

   display_arbiter #(.HOLD_CYC(4), .IDLE_HEX(16'h0000), .IDLE_DOTS(4'hF), .BLINK_CYC(2)) dut (
      .clk(clk), .reset(reset), .req(req), .dat0(dat0), .dat1(dat1), .dat2(dat2),
      .blink(blink), .gnt(gnt), .hexa3(hexa3), .hexa2(hexa2), .hexa1(hexa1), .hexa0(hexa0),
      .puntos4(puntos4), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; req = '0; blink = '0;
      tick(1);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = '0; blink = '0;
      dat0 = '0; dat1 = '0; dat2 = '0;
      tick(2);
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      checks++; if (hex !== 16'h0000) begin failures++; $display("FAIL reset_hex got=%h exp=0000", hex); end
      checks++; if (puntos4 !== 4'hF) begin failures++; $display("FAIL reset_dots got=%h exp=f", puntos4); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b1;
      tick(3);
      checks++; if ({gnt, hex, puntos4, busy} !== {3'b000, 16'h0000, 4'hF, 1'b0}) begin
         failures++; $display("FAIL idle_noreq got=%b/%h/%h/%b exp=000/0000/f/0", gnt, hex, puntos4, busy); end
   endtask

   task automatic test_single();
      do_reset();
      req = 3'b001; dat0 = 20'h12345; dat1 = 20'hABCD0;
      tick(1);
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL single_gnt got=%b exp=001", gnt); end
      checks++; if (hex !== 16'h0000) begin failures++; $display("FAIL single_hex_lag got=%h exp=0000", hex); end
      tick(1);
      checks++; if (hex !== 16'h1234) begin failures++; $display("FAIL single_hex got=%h exp=1234", hex); end
      checks++; if (puntos4 !== 4'h5) begin failures++; $display("FAIL single_dots got=%h exp=5", puntos4); end
      dat1 = 20'hFFFFF;
      tick(1);
      checks++; if (hex !== 16'h1234) begin failures++; $display("FAIL single_ignore got=%h exp=1234", hex); end
   endtask

   task automatic test_timeslice();
      do_reset();
      req = 3'b011; dat0 = 20'h12345; dat1 = 20'hABCD0;
      tick(5);
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL ts_hold0 got=%b exp=001", gnt); end
      tick(1);
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL ts_switch1 got=%b exp=010", gnt); end
      checks++; if (hex !== 16'h1234) begin failures++; $display("FAIL ts_hex_lag got=%h exp=1234", hex); end
      tick(1);
      checks++; if ({hex, puntos4} !== 20'hABCD0) begin failures++; $display("FAIL ts_hex1 got=%h exp=abcd0", {hex, puntos4}); end
      tick(3);
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL ts_hold1 got=%b exp=010", gnt); end
      tick(1);
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL ts_back0 got=%b exp=001", gnt); end
      tick(1);
      checks++; if (hex !== 16'h1234) begin failures++; $display("FAIL ts_hex0 got=%h exp=1234", hex); end
   endtask

   task automatic test_linger();
      for (int v = 0; v < 3; v++) begin
         do_reset();
         req = 3'b001; dat0 = 20'h12345; dat2 = 20'h98763;
         tick(2);
         req = 3'b000;
         tick(1);
         checks++; if ({gnt, busy, hex} !== {3'b000, 1'b1, 16'h1234}) begin
            failures++; $display("FAIL linger_enter v=%0d got=%b/%b/%h exp=000/1/1234", v, gnt, busy, hex); end
         if (v == 1) req = 3'b100;
         if (v == 2) req = 3'b001;
         tick(2);
         checks++; if ({gnt, busy, hex} !== {3'b000, 1'b1, 16'h1234}) begin
            failures++; $display("FAIL linger_hold v=%0d got=%b/%b/%h exp=000/1/1234", v, gnt, busy, hex); end
         tick(1);
         if (v == 0) begin
            checks++; if ({gnt, busy, hex, puntos4} !== {3'b000, 1'b0, 16'h0000, 4'hF}) begin
               failures++; $display("FAIL linger_idle got=%b/%b/%h/%h exp=000/0/0000/f", gnt, busy, hex, puntos4); end
         end else if (v == 1) begin
            checks++; if ({gnt, hex} !== {3'b100, 16'h1234}) begin
               failures++; $display("FAIL linger_grant2 got=%b/%h exp=100/1234", gnt, hex); end
            tick(1);
            checks++; if ({hex, puntos4} !== 20'h98763) begin
               failures++; $display("FAIL linger_hex2 got=%h exp=98763", {hex, puntos4}); end
         end else begin
            checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL linger_regrant0 got=%b exp=001", gnt); end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 3'b001; dat0 = 20'h12345;
      tick(3);
      reset = 1'b0;
      tick(1);
      checks++; if ({gnt, busy, hex, puntos4} !== {3'b000, 1'b0, 16'h0000, 4'hF}) begin
         failures++; $display("FAIL mid_reset got=%b/%b/%h/%h exp=000/0/0000/f", gnt, busy, hex, puntos4); end
      req = 3'b111; reset = 1'b1;
      tick(1);
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL mid_first got=%b exp=001", gnt); end
      tick(5);
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL mid_next got=%b exp=010", gnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      req = 3'b001; dat0 = 20'h12345; dat1 = 20'hABCD0;
      tick(9);
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL b2b_sat got=%b exp=001", gnt); end
      req = 3'b010;
      tick(1);
      checks++; if ({gnt, busy, hex} !== {3'b010, 1'b1, 16'h1234}) begin
         failures++; $display("FAIL b2b_direct got=%b/%b/%h exp=010/1/1234", gnt, busy, hex); end
      tick(1);
      checks++; if (hex !== 16'hABCD) begin failures++; $display("FAIL b2b_hex got=%h exp=abcd", hex); end
   endtask

   task automatic test_blink();
      logic [3:0] p [8];
      int bad;
      do_reset();
      req = 3'b001; blink = 3'b001; dat0 = 20'h12340;
      tick(2);
      for (int i = 0; i < 8; i++) begin
         p[i] = puntos4;
         tick(1);
      end
      bad = 0;
`ifdef DISPLAY_ARBITER_BLINK_EN
      for (int i = 0; i < 8; i++) if (p[i] !== 4'h0 && p[i] !== 4'hF) bad++;
      for (int i = 0; i < 6; i++) if (p[i + 2] !== ~p[i]) bad++;
`else
      for (int i = 0; i < 8; i++) if (p[i] !== 4'h0) bad++;
`endif
      checks++; if (bad !== 0) begin
         failures++; $display("FAIL blink_dots bad=%0d exp=0 seq=%h%h%h%h%h%h%h%h", bad,
                              p[0], p[1], p[2], p[3], p[4], p[5], p[6], p[7]); end
      checks++; if (hex !== 16'h1234) begin failures++; $display("FAIL blink_hex got=%h exp=1234", hex); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_timeslice();
      test_linger();
      test_reset_mid();
      test_back_to_back();
      test_blink();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
